present_key_sequencer: RTL and testbench

//  Sequences the PRESENT-80 key schedule across all rounds. It loads an 80-bit key
//  and iterates the key-update function once per accepted round key.
//  It streams the 32 round keys K1..K32 (64 bit each) to the cipher round datapath

---
 rtl/present_pkg.sv | 38 +++
 rtl/present_key_update.sv | 33 +++
 rtl/present_key_sequencer.sv | 105 ++++++++++
 tb/tb_present_key_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared constants, S-box and FSM state type for the PRESENT-80 key schedule.
package present_pkg;

  localparam int unsigned KEY_W  = 80;
  localparam int unsigned RK_W   = 64;
  localparam int unsigned ROUNDS = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'hC;
      4'h1:    y = 4'h5;
      4'h2:    y = 4'h6;
      4'h3:    y = 4'hB;
      4'h4:    y = 4'h9;
      4'h5:    y = 4'h0;
      4'h6:    y = 4'hA;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'h3;
      4'h9:    y = 4'hE;
      4'hA:    y = 4'hF;
      4'hB:    y = 4'h8;
      4'hC:    y = 4'h4;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h1;
      4'hF:    y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/present_key_update.sv
// Combinational PRESENT-80 key update: rotate left 61, S-box top nibble, xor round counter.
module present_sbox
  import present_pkg::*;
(
  input  logic [3:0] nib_in,
  input  logic [3:0] nib_unused_guard,
  output logic [3:0] nib_out
);
  logic [3:0] guard_s;
  assign guard_s = nib_unused_guard & 4'h0;
  assign nib_out = sbox(nib_in) | guard_s;
endmodule

module present_key_update
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key_in,
  input  logic [4:0]       rc,
  output logic [KEY_W-1:0] key_out
);
  logic [KEY_W-1:0] rot_s;
  logic [3:0]       sbox_out_s;

  assign rot_s = {key_in[18:0], key_in[79:19]};

  present_sbox u_sbox (
    .nib_in           (rot_s[79:76]),
    .nib_unused_guard (4'h0),
    .nib_out          (sbox_out_s)
  );

  assign key_out = {sbox_out_s, rot_s[75:20], rot_s[19:15] ^ rc, rot_s[14:0]};
endmodule

// File: rtl/present_key_sequencer.sv
// Streams the 32 PRESENT-80 round keys over valid/ready, one key update per accepted key.
module present_key_sequencer
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic             rk_ready,
  output logic             rk_valid,
  output logic [RK_W-1:0]  rk_data,
  output logic [4:0]       rk_index,
  output logic             busy,
  output logic             done
);
  localparam logic [4:0] LAST_IDX = 5'(ROUNDS);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [4:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [KEY_W-1:0] key_next_s;
  logic [4:0]       rc_s;

  // The round counter for the next key is one ahead of the index being presented.
  assign rc_s = idx_q + 5'd1;

  present_key_update u_update (
    .key_in  (key_q),
    .rc      (rc_s),
    .key_out (key_next_s)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          key_d   = key_in;
          idx_d   = 5'd0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (valid_q && rk_ready) begin
          if (idx_q != LAST_IDX) begin
            key_d = key_next_s;
            idx_d = idx_q + 5'd1;
          end else begin
            state_d = FIN;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          state_d = RUN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All outputs come straight from these flops, so rk_ready never reaches rk_data combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= {KEY_W{1'b0}};
      idx_q   <= 5'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid = valid_q;
  assign rk_data  = key_q[79:16];
  assign rk_index = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_present_key_sequencer.sv
// Directed bench for present_key_sequencer with an independent key-schedule reference.
module tb_present_key_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [79:0] key_in;
  logic        rk_ready;
  logic        rk_valid;
  logic [63:0] rk_data;
  logic [4:0]  rk_index;
  logic        busy;
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0]  sb_tbl [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [79:0] gk     [32];
  logic [63:0] obs_rk [32];

  present_key_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_data  (rk_data),
    .rk_index (rk_index),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] gupd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = (k << 61) | (k >> 19);
    r[79:76] = sb_tbl[r[79:76]];
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  task automatic gen(input logic [79:0] key);
    gk[0] = key;
    for (int i = 1; i < 32; i++) gk[i] = gupd(gk[i-1], 5'(i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = 80'h0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Starts a run with rk_ready high and checks every key; returns in the done cycle.
  task automatic run_full(input string tag, input logic [79:0] key);
    gen(key);
    key_in = key; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk({tag, "_rk"},    {16'h0, rk_data},   {16'h0, gk[i][79:16]});
      chk({tag, "_idx"},   {75'h0, rk_index},  80'(i));
      chk({tag, "_valid"}, {79'h0, rk_valid},  80'h1);
      obs_rk[i] = rk_data;
      tick();
    end
    chk({tag, "_done"},     {79'h0, done},     80'h1);
    chk({tag, "_fin_valid"},{79'h0, rk_valid}, 80'h0);
    chk({tag, "_fin_busy"}, {79'h0, busy},     80'h0);
    chk({tag, "_fin_idx"},  {75'h0, rk_index}, 80'd31);
  endtask

  initial begin
    logic [79:0] key_a;
    logic [79:0] key_b;
    int  eidx;
    int  hs;
    bit  done_seen;
    int  stall_left;
    bit  stalled_once;
    bit  r;

    key_a = 80'h0123_4567_89AB_CDEF_0123;
    key_b = 80'hDEAD_BEEF_CAFE_F00D_1234;

    // Reset state, and rk_ready while idle has no effect.
    do_reset();
    chk("rst_valid", {79'h0, rk_valid}, 80'h0);
    chk("rst_busy",  {79'h0, busy},     80'h0);
    chk("rst_done",  {79'h0, done},     80'h0);
    chk("rst_data",  {16'h0, rk_data},  80'h0);
    chk("rst_idx",   {75'h0, rk_index}, 80'h0);
    rk_ready = 1'b1;
    tick(); tick();
    chk("idle_ready_valid", {79'h0, rk_valid}, 80'h0);
    chk("idle_ready_idx",   {75'h0, rk_index}, 80'h0);

    // 1: all-zero key with hand-computed round keys.
    run_full("t1", 80'h0);
    chk("t1_K1",  {16'h0, obs_rk[0]},  80'h0);
    chk("t1_K2",  {16'h0, obs_rk[1]},  {16'h0, 64'hC000_0000_0000_0000});
    chk("t1_K32", {16'h0, obs_rk[31]}, {16'h0, 64'h6DAB_3174_4F41_D700});
    tick();
    chk("t1_done_once", {79'h0, done}, 80'h0);

    // 2: all-ones key.
    do_reset();
    run_full("t2", {80{1'b1}});
    chk("t2_K1", {16'h0, obs_rk[0]}, {16'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    chk("t2_K2", {16'h0, obs_rk[1]}, {16'h0, 64'h2FFF_FFFF_FFFF_FFFF});

    // 3: pseudo-random rk_ready plus a 10-cycle stall.
    do_reset();
    gen(key_a);
    key_in = key_a; start = 1'b1; rk_ready = 1'b0;
    tick();
    start = 1'b0;
    eidx = 0; hs = 0; done_seen = 1'b0; stall_left = 0; stalled_once = 1'b0;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      if (hs == 10 && !stalled_once) begin
        stalled_once = 1'b1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end else begin
        r = 1'($urandom_range(0, 1));
      end
      rk_ready = r;
      tick();
      if (r) begin
        hs++;
        if (eidx == 31) begin
          chk("t3_done", {79'h0, done}, 80'h1);
          done_seen = 1'b1;
        end else begin
          eidx++;
        end
      end
      if (!done_seen) begin
        chk("t3_rk",    {16'h0, rk_data},  {16'h0, gk[eidx][79:16]});
        chk("t3_idx",   {75'h0, rk_index}, 80'(eidx));
        chk("t3_valid", {79'h0, rk_valid}, 80'h1);
      end
    end
    chk("t3_finished", {79'h0, done_seen}, 80'h1);
    chk("t3_handshakes", 80'(hs), 80'd32);

    // 4: start mid-run with another key is ignored.
    do_reset();
    gen(key_a);
    key_in = key_a; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("t4_rk", {16'h0, rk_data}, {16'h0, gk[i][79:16]});
      if (i == 5) begin
        key_in = key_b;
        start  = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("t4_done", {79'h0, done}, 80'h1);

    // 5: rst at index 12 (with start in the same cycle) aborts the run.
    do_reset();
    gen(key_a);
    key_in = key_a; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("t5_idx12", {75'h0, rk_index}, 80'd12);
    rst = 1'b1; start = 1'b1; key_in = key_b;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("t5_valid", {79'h0, rk_valid}, 80'h0);
    chk("t5_busy",  {79'h0, busy},     80'h0);
    chk("t5_done",  {79'h0, done},     80'h0);
    chk("t5_data",  {16'h0, rk_data},  80'h0);
    chk("t5_idx",   {75'h0, rk_index}, 80'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_done", {79'h0, done}, 80'h0);
    end
    key_in = key_b; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_new_K1",    {16'h0, rk_data},  {16'h0, key_b[79:16]});
    chk("t5_new_valid", {79'h0, rk_valid}, 80'h1);

    // 6: start during done is ignored; start in the cycle after done is accepted.
    do_reset();
    run_full("t6", key_a);
    key_in = key_b; start = 1'b1;
    tick();
    chk("t6_fin_start_ign", {79'h0, rk_valid}, 80'h0);
    chk("t6_done_cleared",  {79'h0, done},     80'h0);
    key_in = 80'h0;
    tick();
    start = 1'b0;
    chk("t6_b2b_valid", {79'h0, rk_valid}, 80'h1);
    chk("t6_b2b_K1",    {16'h0, rk_data},  80'h0);
    chk("t6_b2b_busy",  {79'h0, busy},     80'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
